regu_mp: RTL and testbench

REGU_MP -- requirements
Module: regu_mp

---
 rtl/regu_pkg.sv | 13 +
 rtl/regu_scoreboard.sv | 57 +++++
 rtl/regu_mp.sv | 99 +++++++++
 tb/tb_regu_mp.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regu_pkg.sv
// Shared constants and types for the regu_mp multi-ported register file.
package regu_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_REG_WIDTH = 5;

    typedef logic [DEFAULT_REG_WIDTH-1:0] reg_idx_t;
    typedef logic [DEFAULT_WIDTH-1:0]     reg_data_t;

    // Architectural zero register: reads as 0, never written, never busy.
    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regu_scoreboard.sv
// Busy-bit scoreboard for regu_mp.
// A register goes busy when an instruction targeting it issues and goes idle
// when any write port commits to it. An issue wins over a same-cycle write,
// because the issued instruction is a newer producer still pending.
module regu_scoreboard
    import regu_pkg::*;
#(
    parameter int REG_WIDTH = DEFAULT_REG_WIDTH,
    parameter int NR_RD     = 2,
    parameter int NR_WR     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iss_valid,
    input  logic [REG_WIDTH-1:0]       iss_rd,
    input  logic [NR_WR-1:0]           clr_en,
    input  logic [NR_WR*REG_WIDTH-1:0] clr_addr,
    input  logic [NR_RD*REG_WIDTH-1:0] lk_addr,
    output logic [NR_RD-1:0]           lk_busy
);

    localparam int DEPTH = 2**REG_WIDTH;

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    // Next busy vector: clears first, then the issue so that set wins.
    always_comb begin
        busy_next = busy_reg;
        for (int j = 0; j < NR_WR; j++) begin
            if (clr_en[j]) begin
                busy_next[clr_addr[j*REG_WIDTH +: REG_WIDTH]] = 1'b0;
            end
        end
        if (iss_valid) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Busy register; reset discards any concurrent issue or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NR_RD; gi++) begin : g_lookup
            assign lk_busy[gi] = busy_reg[lk_addr[gi*REG_WIDTH +: REG_WIDTH]];
        end
    endgenerate

endmodule

// File: rtl/regu_mp.sv
// Multi-ported register file with a busy-bit scoreboard.
// Combinational reads, synchronous writes (highest-index port wins on a
// collision), register 0 hardwired to zero.
// Optional feature: define REGU_MP_BYPASS_EN to forward same-cycle write data
// to matching read ports and to mask the busy bit those writes will clear.
module regu_mp
    import regu_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int REG_WIDTH = DEFAULT_REG_WIDTH,
    parameter int NR_RD     = 2,
    parameter int NR_WR     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NR_RD*REG_WIDTH-1:0] rd_addr,
    output logic [NR_RD*WIDTH-1:0]     rd_data,
    output logic [NR_RD-1:0]           rd_busy,
    input  logic [NR_WR-1:0]           wr_en,
    input  logic [NR_WR*REG_WIDTH-1:0] wr_addr,
    input  logic [NR_WR*WIDTH-1:0]     wr_data,
    input  logic                       iss_valid,
    input  logic [REG_WIDTH-1:0]       iss_rd
);

    localparam int                   DEPTH    = 2**REG_WIDTH;
    localparam logic [REG_WIDTH-1:0] IDX_ZERO = REG_WIDTH'(REG_ZERO);

    logic [WIDTH-1:0] regs_reg [DEPTH];
    logic [NR_WR-1:0] wr_commit;
    logic [NR_RD-1:0] sb_busy;

    // A write port commits only when enabled and not aimed at the zero register.
    genvar gi;
    generate
        for (gi = 0; gi < NR_WR; gi++) begin : g_commit
            assign wr_commit[gi] = wr_en[gi] &&
                                   (wr_addr[gi*REG_WIDTH +: REG_WIDTH] != IDX_ZERO);
        end
    endgenerate

    // Register array: ascending port loop lets the highest-index port win.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_reg[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NR_WR; j++) begin
                if (wr_commit[j]) begin
                    regs_reg[wr_addr[j*REG_WIDTH +: REG_WIDTH]] <= wr_data[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    regu_scoreboard #(
        .REG_WIDTH (REG_WIDTH),
        .NR_RD     (NR_RD),
        .NR_WR     (NR_WR)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .clr_en    (wr_commit),
        .clr_addr  (wr_addr),
        .lk_addr   (rd_addr),
        .lk_busy   (sb_busy)
    );

    generate
        for (gi = 0; gi < NR_RD; gi++) begin : g_read
            logic [REG_WIDTH-1:0] ra;
            logic [WIDTH-1:0]     rd_val_next;
            logic                 byp_hit_next;

            assign ra = rd_addr[gi*REG_WIDTH +: REG_WIDTH];

            // Read mux: array value, optionally overridden by a same-cycle write.
            always_comb begin
                rd_val_next  = (ra == IDX_ZERO) ? '0 : regs_reg[ra];
                byp_hit_next = 1'b0;
`ifdef REGU_MP_BYPASS_EN
                for (int j = 0; j < NR_WR; j++) begin
                    if (wr_commit[j] && (wr_addr[j*REG_WIDTH +: REG_WIDTH] == ra)) begin
                        rd_val_next  = wr_data[j*WIDTH +: WIDTH];
                        byp_hit_next = 1'b1;
                    end
                end
`endif
            end

            assign rd_data[gi*WIDTH +: WIDTH] = rd_val_next;
            assign rd_busy[gi]                = sb_busy[gi] & ~byp_hit_next;
        end
    endgenerate

endmodule

// File: tb/tb_regu_mp.sv
// Directed testbench for regu_mp. Stimulus pushes expected read results into
// a queue; a monitor on the falling edge pops and compares them.
`timescale 1ns/1ps
module tb_regu_mp;

    localparam int W  = 32;
    localparam int RW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

`ifdef REGU_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*RW-1:0]  rd_addr;
    logic [NR*W-1:0]   rd_data;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     wr_en;
    logic [NW*RW-1:0]  wr_addr;
    logic [NW*W-1:0]   wr_data;
    logic              iss_valid;
    logic [RW-1:0]     iss_rd;

    regu_mp dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        busy;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    // Monitor: each falling edge, check every expectation queued this cycle.
    initial begin
        exp_t e;
        logic [31:0] ad;
        logic        ab;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e  = q.pop_front();
                ad = rd_data[e.port*W +: W];
                ab = rd_busy[e.port];
                n_vec++;
                if (ad !== e.data) begin
                    n_fail++;
                    $display("FAIL %s port%0d data: got %h want %h", e.name, e.port, ad, e.data);
                end
                n_vec++;
                if (ab !== e.busy) begin
                    n_fail++;
                    $display("FAIL %s port%0d busy: got %b want %b", e.name, e.port, ab, e.busy);
                end
                $display("check %s port%0d data=%h busy=%b", e.name, e.port, ad, ab);
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: simulation did not finish in time");
            $fatal(1, "watchdog");
        end
    end

    task automatic idle();
        rst       = 1'b0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        rd_addr   = '0;
    endtask

    task automatic set_rd(input int p, input logic [RW-1:0] a);
        rd_addr[p*RW +: RW] = a;
    endtask

    task automatic set_wr(input int p, input logic [RW-1:0] a, input logic [W-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*RW +: RW] = a;
        wr_data[p*W +: W]   = d;
    endtask

    task automatic expect_rd(input int p, input logic [31:0] d, input logic b, input string nm);
        exp_t e;
        e.port = p;
        e.data = d;
        e.busy = b;
        e.name = nm;
        q.push_back(e);
    endtask

    // Advance to just after the next rising edge and clear the inputs.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle();

        // All registers read zero and idle after reset.
        for (int a = 0; a < 16; a++) begin
            set_rd(0, RW'(2*a + 1));
            set_rd(1, RW'(2*a + 2));
            expect_rd(0, 32'h0, 1'b0, "reset_rd");
            expect_rd(1, 32'h0, 1'b0, "reset_rd");
            step();
        end

        // x5 = DEADBEEF; same-cycle read of x5 shows old value unless bypassed.
        set_wr(0, 5'd5, 32'hDEADBEEF);
        set_rd(0, 5'd5);
        expect_rd(0, BYP ? 32'hDEADBEEF : 32'h0, 1'b0, "x5_same_cycle");
        step();
        set_rd(0, 5'd5);
        expect_rd(0, 32'hDEADBEEF, 1'b0, "x5_read");
        step();

        // Writes to x0 are discarded.
        set_wr(0, 5'd0, 32'h1234);
        set_rd(1, 5'd0);
        expect_rd(1, 32'h0, 1'b0, "x0_same_cycle");
        step();
        set_rd(0, 5'd0);
        expect_rd(0, 32'h0, 1'b0, "x0_read");
        step();

        // Colliding writes to x7: port 1 wins.
        set_wr(0, 5'd7, 32'h11);
        set_wr(1, 5'd7, 32'h22);
        step();
        set_rd(0, 5'd7);
        set_rd(1, 5'd7);
        expect_rd(0, 32'h22, 1'b0, "x7_collide");
        expect_rd(1, 32'h22, 1'b0, "x7_collide");
        step();

        // Read-during-write of x3.
        set_wr(0, 5'd3, 32'hA);
        step();
        set_wr(1, 5'd3, 32'hB);
        set_rd(0, 5'd3);
        set_rd(1, 5'd3);
        expect_rd(0, BYP ? 32'hB : 32'hA, 1'b0, "x3_rdw");
        expect_rd(1, BYP ? 32'hB : 32'hA, 1'b0, "x3_rdw");
        step();
        set_rd(0, 5'd3);
        expect_rd(0, 32'hB, 1'b0, "x3_after");
        step();

        // Scoreboard: issue x9, then write x9 to clear it.
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        set_rd(0, 5'd9);
        expect_rd(0, 32'h0, 1'b0, "x9_issue_cycle");
        step();
        set_rd(0, 5'd9);
        expect_rd(0, 32'h0, 1'b1, "x9_busy");
        step();
        set_wr(1, 5'd9, 32'h99);
        set_rd(0, 5'd9);
        expect_rd(0, BYP ? 32'h99 : 32'h0, BYP ? 1'b0 : 1'b1, "x9_wr_cycle");
        step();
        set_rd(0, 5'd9);
        expect_rd(0, 32'h99, 1'b0, "x9_cleared");
        step();

        // Issue and write x9 together: busy stays set.
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        set_wr(0, 5'd9, 32'h100);
        step();
        set_rd(0, 5'd9);
        set_rd(1, 5'd9);
        expect_rd(0, 32'h100, 1'b1, "x9_iss_wr");
        expect_rd(1, 32'h100, 1'b1, "x9_iss_wr");
        step();

        // Issue to x0 never marks it busy.
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        step();
        set_rd(0, 5'd0);
        expect_rd(0, 32'h0, 1'b0, "x0_issue");
        step();

        // Reset discards a concurrent write and issue.
        set_wr(0, 5'd4, 32'h44);
        step();
        set_rd(0, 5'd4);
        expect_rd(0, 32'h44, 1'b0, "x4_pre_reset");
        step();
        rst       = 1'b1;
        set_wr(0, 5'd4, 32'h55);
        iss_valid = 1'b1;
        iss_rd    = 5'd6;
        step();
        set_rd(0, 5'd4);
        set_rd(1, 5'd6);
        expect_rd(0, 32'h0, 1'b0, "x4_post_reset");
        expect_rd(1, 32'h0, 1'b0, "x6_post_reset");
        step();
        set_rd(0, 5'd5);
        set_rd(1, 5'd9);
        expect_rd(0, 32'h0, 1'b0, "x5_post_reset");
        expect_rd(1, 32'h0, 1'b0, "x9_post_reset");
        step();

        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
